// File: rtl/adder8_if.sv
// Operand/result bundle for adder8: the master drives operands and in_valid,
// the slave (adder) returns the combinational and registered results.
interface adder8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             out_valid;

  modport master (
    output in1, in2, in_valid,
    input  sum, carry, ovf, zero, sum_q, carry_q, ovf_q, out_valid
  );

  modport slave (
    input  in1, in2, in_valid,
    output sum, carry, ovf, zero, sum_q, carry_q, ovf_q, out_valid
  );
endinterface

// File: rtl/adder8.sv
// Unsigned ripple-carry adder with carry-out, signed-overflow and zero flags,
// plus a one-stage registered copy of the result qualified by in_valid.
module adder8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder8 #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  adder8_if.slave bus
);
  localparam int STAGES = 1;
  localparam int MSB    = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } res_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  res_t             res_d;
  res_t             res_q;
  logic [STAGES:0]  vld_pipe;

  assign c[0] = 1'b0;

  // One full-adder cell per bit; carry ripples LSB to MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    adder8_fa u_fa (
      .a  (bus.in1[gi]),
      .b  (bus.in2[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  assign res_d.sum   = s;
  assign res_d.carry = c[WIDTH];
  assign res_d.ovf   = (bus.in1[MSB] == bus.in2[MSB]) && (s[MSB] != bus.in1[MSB]);

  assign bus.sum   = res_d.sum;
  assign bus.carry = res_d.carry;
  assign bus.ovf   = res_d.ovf;
  assign bus.zero  = ~|s;

  assign vld_pipe[0] = bus.in_valid;

  // Reset beats a coincident in_valid; without in_valid the result holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q              <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      if (vld_pipe[0]) res_q <= res_d;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign bus.sum_q     = res_q.sum;
  assign bus.carry_q   = res_q.carry;
  assign bus.ovf_q     = res_q.ovf;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_adder8.sv
// Directed bench for adder8: combinational vectors, random 9-bit sums,
// registered path, hold behaviour and reset/in_valid collision.
module tb_adder8;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  adder8_if #(.WIDTH(8)) bus ();

  adder8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] esum, input logic ecarry,
                      input logic eovf, input logic ezero);
    bus.in1 = a;
    bus.in2 = b;
    #1;
    chk({tag, ".sum"},   32'(bus.sum),   32'(esum));
    chk({tag, ".carry"}, 32'(bus.carry), 32'(ecarry));
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(eovf));
    chk({tag, ".zero"},  32'(bus.zero),  32'(ezero));
  endtask

  task automatic regchk(input string tag, input logic [7:0] esum, input logic ec,
                        input logic eo, input logic ev);
    chk({tag, ".sum_q"},     32'(bus.sum_q),     32'(esum));
    chk({tag, ".carry_q"},   32'(bus.carry_q),   32'(ec));
    chk({tag, ".ovf_q"},     32'(bus.ovf_q),     32'(eo));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
  endtask

  initial begin
    logic [7:0] a, b;
    logic [8:0] full;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in1      = 8'd0;
    bus.in2      = 8'd0;

    // Reset state, with combinational outputs live during reset
    @(posedge clk); #1;
    regchk("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    comb("zero", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    rst = 1'b0;

    comb("small",    8'd5,   8'd10,  8'd15,  1'b0, 1'b0, 1'b0);
    comb("to128",    8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0);
    comb("wrap",     8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1);
    comb("200p100",  8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0);
    comb("255p255",  8'd255, 8'd255, 8'd254, 1'b1, 1'b0, 1'b0);
    comb("128p128",  8'd128, 8'd128, 8'd0,   1'b1, 1'b1, 1'b1);
    comb("64p64",    8'd64,  8'd64,  8'd128, 1'b0, 1'b1, 1'b0);

    // Random operands against a 9-bit reference sum
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      bus.in1 = a;
      bus.in2 = b;
      full = {1'b0, a} + {1'b0, b};
      #1;
      chk($sformatf("rand%0d(%0d+%0d)", i, a, b), 32'({bus.carry, bus.sum}), 32'(full));
    end

    // Registered path: one-cycle reset pulse
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    regchk("rst_pulse", 8'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in1      = 8'd255;
    bus.in2      = 8'd255;
    @(posedge clk); #1;
    regchk("cap255", 8'd254, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in1      = 8'd5;
    bus.in2      = 8'd10;
    @(posedge clk); #1;
    regchk("hold", 8'd254, 1'b1, 1'b0, 1'b0);

    // Back-to-back captures
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1      = 8'd127;
    bus.in2      = 8'd1;
    @(posedge clk); #1;
    regchk("b2b0", 8'd128, 1'b0, 1'b1, 1'b1);

    @(negedge clk);
    bus.in1 = 8'd200;
    bus.in2 = 8'd100;
    @(posedge clk); #1;
    regchk("b2b1", 8'd44, 1'b1, 1'b0, 1'b1);

    // Reset coincident with in_valid: input dropped, comb path still live
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in1      = 8'd5;
    bus.in2      = 8'd10;
    @(posedge clk); #1;
    regchk("collide", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("collide.sum", 32'(bus.sum), 32'd15);

    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post.out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
